mc_inject_ctrl: RTL and testbench
=================================

// Module: mc_inject_ctrl
// PURPOSE
//  Per-node injection controller for the bufferless multicast (CARPOOL) router.
//  Queues local send requests and builds the header fields {mc, dst, dstList}
//  that the router's route computation consumes. Injects a flit only into an
//  empty pipeline slot, and raises a starvation flag when the head waits too long.
// PARAMETERS
//  NUM_NODE       16  nodes in the network; width of dstList
//  DST_WIDTH      4   unicast destination index width (clog2 NUM_NODE)
//  LOCAL_ID       0   this node's index
//  FIFO_DEPTH     4   request queue entries (power of 2)
//  SEQ_WIDTH      8   per-node injection sequence number width
//  STARVE_THRESH  15  head-wait cycles before starve_req asserts
// PORTS
//  clk          in   1          clock, rising edge
//  reset_n      in   1          async active-low reset
//  req_valid    in   1          core send request
//  req_ready    out  1          queue can accept; transfer when valid&ready
//  req_mc       in   1          1 = multicast, use req_dstList
//  req_dst      in   DST_WIDTH  unicast destination
//  req_dstList  in   NUM_NODE   multicast destination bit vector
//  slot_free    in   1          router local input slot empty this cycle
//  inj_valid    out  1          registered: flit presented to router this cycle
//  inj_mc       out  1          header mc bit
//  inj_dst      out  DST_WIDTH  header unicast dst
//  inj_dstList  out  NUM_NODE   header dstList (LOCAL_ID bit always 0)
//  inj_seq      out  SEQ_WIDTH  sequence number
//  self_deliver out  1          1-cycle pulse: request included LOCAL_ID
//  starve_req   out  1          head blocked >= STARVE_THRESH cycles
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, seq = 0, wait counter = 0; req_ready = 1
//   once reset_n deasserts. Async assert aborts any in-flight head (it is lost).
//  Enqueue normalisation (registered into the FIFO, 1-cycle enqueue latency):
//   - mc=1: clear LOCAL_ID bit. If that bit was set, pulse self_deliver next cycle.
//   - mc=1, 0 bits left: no enqueue (self-only request).
//   - mc=1, 1 bit left: convert to unicast (mc=0, dst = that bit's index).
//   - mc=0 with dst==LOCAL_ID: no enqueue; pulse self_deliver.
//   - Stored dstList is 0 for unicast entries; dst is 0 for multicast entries.
//  req_ready = !full. A full queue ignores req_valid. Simultaneous enqueue and
//   dequeue while full is not allowed (ready is already 0).
//  FSM: IDLE (queue empty) -> WAIT (head present, !slot_free) -> INJECT.
//   - From IDLE or WAIT, if the head is present and slot_free=1, the next cycle
//     is INJECT: inj_* hold the head, inj_valid=1 for exactly one cycle, the
//     head is popped, and seq increments with wrap (2^SEQ_WIDTH-1 -> 0).
//   - From INJECT: go to WAIT or INJECT if more entries are queued, else IDLE.
//     Back-to-back injection is allowed when slot_free stays 1.
//   - Minimum latency from request accept to inj_valid is 2 cycles.
//   - inj_* hold their value when inj_valid=0 (no fields are zeroed).
//  Wait counter: counts cycles in WAIT with a head present and saturates at
//   STARVE_THRESH. It clears on injection or when the queue is empty.
//   starve_req = (count == STARVE_THRESH); it drops in the cycle after injection.
// TESTING
//  - Reset mid-WAIT with 3 entries queued -> inj_valid=0, req_ready=1, seq=0,
//    starve_req=0 in the cycle after reset_n rises.
//  - Unicast dst=5, slot_free=1 -> inj_valid 2 cycles after accept; inj_mc=0,
//    inj_dst=5, inj_seq=0.
//  - mc dstList=16'h0011, LOCAL_ID=0 -> self_deliver pulse and a unicast inject
//    with inj_dst=4. dstList=16'h0001 -> self_deliver only, no inject.
//  - mc dstList=16'h8421 -> inj_mc=1, inj_dstList=16'h8420.
//  - Fill 4 entries while slot_free=0 -> req_ready=0 after the 4th;
//    starve_req rises 15 cycles into WAIT. slot_free=1 -> 4 back-to-back
//    injects, seq 0..3 in FIFO order.
//  - 256 injections -> inj_seq wraps from 255 to 0.

Source files
------------

// File: rtl/mc_inject_ctrl.sv
// Injection controller for the bufferless multicast router: queues local send
// requests, normalises their headers and injects one flit per free pipeline slot.
module mc_inject_ctrl #(
  parameter int unsigned NUM_NODE      = 16,
  parameter int unsigned DST_WIDTH     = 4,
  parameter int unsigned LOCAL_ID      = 0,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SEQ_WIDTH     = 8,
  parameter int unsigned STARVE_THRESH = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_mc,
  input  logic [DST_WIDTH-1:0] req_dst,
  input  logic [NUM_NODE-1:0]  req_dstList,
  input  logic                 slot_free,
  output logic                 inj_valid,
  output logic                 inj_mc,
  output logic [DST_WIDTH-1:0] inj_dst,
  output logic [NUM_NODE-1:0]  inj_dstList,
  output logic [SEQ_WIDTH-1:0] inj_seq,
  output logic                 self_deliver,
  output logic                 starve_req
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = $clog2(STARVE_THRESH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_INJECT = 2'd2
  } state_t;

  state_t               state;
  logic                 fifo_mc   [FIFO_DEPTH];
  logic [DST_WIDTH-1:0] fifo_dst  [FIFO_DEPTH];
  logic [NUM_NODE-1:0]  fifo_list [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic [SEQ_WIDTH-1:0] seq_cnt;
  logic                 ready_q;

  logic [NUM_NODE-1:0]  local_mask, mc_list, norm_list;
  logic [DST_WIDTH-1:0] enc_dst, norm_dst;
  logic                 single, hit_local, enq_ok, norm_mc;
  logic                 full, empty, accept, push, pop, blocked;

  // Header normalisation: strip the local node, collapse single-target multicast.
  always_comb begin
    local_mask = NUM_NODE'(1) << LOCAL_ID;
    mc_list    = req_dstList & ~local_mask;
    single     = (mc_list != '0) && ((mc_list & (mc_list - NUM_NODE'(1))) == '0);
    enc_dst    = '0;
    for (int unsigned i = 0; i < NUM_NODE; i++) begin
      if (mc_list[i]) enc_dst = DST_WIDTH'(i);
    end
    if (req_mc) begin
      hit_local = |(req_dstList & local_mask);
      enq_ok    = (mc_list != '0);
      norm_mc   = !single;
      norm_dst  = single ? enc_dst : '0;
      norm_list = single ? '0 : mc_list;
    end else begin
      hit_local = (req_dst == DST_WIDTH'(LOCAL_ID));
      enq_ok    = !hit_local;
      norm_mc   = 1'b0;
      norm_dst  = req_dst;
      norm_list = '0;
    end
  end

  always_comb begin
    full      = (count == CNT_W'(FIFO_DEPTH));
    empty     = (count == '0);
    accept    = req_valid && !full;
    push      = accept && enq_ok;
    pop       = !empty && slot_free;
    blocked   = !empty && !slot_free;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    if (!blocked)
      wait_nxt = '0;
    else if (wait_cnt == WAIT_W'(STARVE_THRESH))
      wait_nxt = wait_cnt;
    else
      wait_nxt = wait_cnt + WAIT_W'(1);
  end

  // Queue storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mc[wr_ptr]   <= norm_mc;
      fifo_dst[wr_ptr]  <= norm_dst;
      fifo_list[wr_ptr] <= norm_list;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      seq_cnt      <= '0;
      ready_q      <= 1'b0;
      self_deliver <= 1'b0;
      starve_req   <= 1'b0;
      inj_mc       <= 1'b0;
      inj_dst      <= '0;
      inj_dstList  <= '0;
      inj_seq      <= '0;
    end else begin
      count        <= count_nxt;
      wait_cnt     <= wait_nxt;
      ready_q      <= (count_nxt != CNT_W'(FIFO_DEPTH));
      self_deliver <= accept && hit_local;
      starve_req   <= (wait_nxt == WAIT_W'(STARVE_THRESH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        state       <= S_INJECT;
        rd_ptr      <= rd_ptr + PTR_W'(1);
        inj_mc      <= fifo_mc[rd_ptr];
        inj_dst     <= fifo_dst[rd_ptr];
        inj_dstList <= fifo_list[rd_ptr];
        inj_seq     <= seq_cnt;
        seq_cnt     <= seq_cnt + SEQ_WIDTH'(1);
      end else if (!empty) begin
        state <= S_WAIT;
      end else begin
        state <= S_IDLE;
      end
    end
  end

  assign inj_valid = (state == S_INJECT);
  assign req_ready = ready_q;

endmodule

// File: tb/tb_mc_inject_ctrl.sv
// Randomised scoreboard bench for mc_inject_ctrl against a queue-based reference model.
module tb_mc_inject_ctrl;

  localparam int unsigned NUM_NODE = 16;
  localparam int unsigned DST_W    = 4;
  localparam int unsigned LOCAL_ID = 0;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned THRESH   = 15;

  typedef struct {
    logic             mc;
    logic [DST_W-1:0] dst;
    logic [15:0]      list;
    logic [SEQ_W-1:0] seq;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_mc = 1'b0;
  logic [DST_W-1:0] req_dst = '0;
  logic [15:0]      req_dstList = '0;
  logic             slot_free = 1'b0;
  logic             inj_valid;
  logic             inj_mc;
  logic [DST_W-1:0] inj_dst;
  logic [15:0]      inj_dstList;
  logic [SEQ_W-1:0] inj_seq;
  logic             self_deliver;
  logic             starve_req;

  mc_inject_ctrl #(
    .NUM_NODE(NUM_NODE), .DST_WIDTH(DST_W), .LOCAL_ID(LOCAL_ID),
    .FIFO_DEPTH(DEPTH), .SEQ_WIDTH(SEQ_W), .STARVE_THRESH(THRESH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mc(req_mc), .req_dst(req_dst), .req_dstList(req_dstList),
    .slot_free(slot_free),
    .inj_valid(inj_valid), .inj_mc(inj_mc), .inj_dst(inj_dst),
    .inj_dstList(inj_dstList), .inj_seq(inj_seq),
    .self_deliver(self_deliver), .starve_req(starve_req)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  ent_t mq[$];
  ent_t sb[$];
  ent_t last;
  int   wcnt = 0;
  logic [SEQ_W-1:0] seq = '0;
  logic exp_valid = 1'b0, exp_ready = 1'b0, exp_self = 1'b0, exp_starve = 1'b0;
  logic saw_wrap = 1'b0;
  logic have_prev = 1'b0;
  logic [SEQ_W-1:0] prev_seq = '0;

  function automatic void normalise(input logic m, input logic [DST_W-1:0] d,
                                    input logic [15:0] l, output bit en,
                                    output bit self, output ent_t e);
    logic [15:0] rest;
    int n;
    e = '{mc: 1'b0, dst: '0, list: '0, seq: '0};
    if (m) begin
      rest = l;
      rest[LOCAL_ID] = 1'b0;
      self = l[LOCAL_ID];
      n = $countones(rest);
      en = (n > 0);
      if (n == 1) begin
        for (int i = 0; i < 16; i++) if (rest[i]) e.dst = DST_W'(i);
      end else begin
        e.mc = 1'b1;
        e.list = rest;
      end
    end else begin
      self = (d == DST_W'(LOCAL_ID));
      en = !self;
      e.dst = d;
    end
  endfunction

  // Reference model: one cycle of queue semantics per rising edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      sb.delete();
      wcnt = 0;
      seq = '0;
      exp_valid = 0; exp_ready = 0; exp_self = 0; exp_starve = 0;
      last = '{mc: 1'b0, dst: '0, list: '0, seq: '0};
      have_prev = 0;
    end else begin
      int sz;
      bit inj, acc, en, self;
      ent_t e;
      sz = mq.size();
      inj = (sz > 0) && slot_free;
      acc = req_valid && (sz < DEPTH);
      self = 0;
      if (inj) begin
        e = mq.pop_front();
        e.seq = seq;
        seq = seq + 1'b1;
        sb.push_back(e);
      end
      if (acc) begin
        normalise(req_mc, req_dst, req_dstList, en, self, e);
        if (en) mq.push_back(e);
      end
      if (sz > 0 && !slot_free) wcnt = (wcnt < THRESH) ? wcnt + 1 : THRESH;
      else wcnt = 0;
      exp_valid  = inj;
      exp_self   = acc && self;
      exp_starve = (wcnt == THRESH);
      exp_ready  = (mq.size() < DEPTH);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs on the falling edge, away from the DUT's active edge.
  task automatic monitor();
    ent_t e;
    chk("inj_valid", 32'(inj_valid), 32'(exp_valid));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("self_deliver", 32'(self_deliver), 32'(exp_self));
    chk("starve_req", 32'(starve_req), 32'(exp_starve));
    if (inj_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inject actual=valid expected=none t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("inj_mc", 32'(inj_mc), 32'(e.mc));
        chk("inj_dst", 32'(inj_dst), 32'(e.dst));
        chk("inj_dstList", 32'(inj_dstList), 32'(e.list));
        chk("inj_seq", 32'(inj_seq), 32'(e.seq));
        if (have_prev && prev_seq == 8'hff && inj_seq == 8'h00) saw_wrap = 1'b1;
        prev_seq = inj_seq;
        have_prev = 1'b1;
        last = e;
      end
    end else begin
      chk("hold_mc", 32'(inj_mc), 32'(last.mc));
      chk("hold_dst", 32'(inj_dst), 32'(last.dst));
      chk("hold_list", 32'(inj_dstList), 32'(last.list));
      chk("hold_seq", 32'(inj_seq), 32'(last.seq));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
  endtask

  task automatic drv(input logic v, input logic m, input logic [DST_W-1:0] d,
                     input logic [15:0] l, input logic sf);
    req_valid = v; req_mc = m; req_dst = d; req_dstList = l; slot_free = sf;
    cyc();
  endtask

  task automatic idle(input int n, input logic sf);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, '0, '0, sf);
  endtask

  initial begin
    int mode;
    logic [15:0] l;
    logic sf;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // Directed header cases
    drv(1'b1, 1'b0, 4'd5, '0, 1'b1);
    idle(3, 1'b1);
    drv(1'b1, 1'b1, '0, 16'h0011, 1'b1);
    idle(3, 1'b1);
    drv(1'b1, 1'b1, '0, 16'h0001, 1'b1);
    idle(3, 1'b1);
    drv(1'b1, 1'b1, '0, 16'h8421, 1'b1);
    idle(3, 1'b1);

    // Fill the queue while the slot is busy, let the head starve, then drain
    for (int i = 1; i <= 4; i++) drv(1'b1, 1'b0, DST_W'(i), '0, 1'b0);
    chk("full_ready", 32'(req_ready), 32'd0);
    idle(20, 1'b0);
    chk("starve_high", 32'(starve_req), 32'd1);
    idle(8, 1'b1);

    // Reset while waiting with three entries queued
    for (int i = 1; i <= 3; i++) drv(1'b1, 1'b0, DST_W'(i + 6), '0, 1'b0);
    idle(4, 1'b0);
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_seq", 32'(inj_seq), 32'd0);

    // Streaming unicast traffic to wrap the sequence number
    for (int i = 0; i < 300; i++) drv(1'b1, 1'b0, 4'd3, '0, 1'b1);
    idle(4, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: l = '0;
        1: l = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: l = (16'(1) << $urandom_range(0, 15)) | 16'($urandom_range(0, 1));
        default: l = 16'($urandom);
      endcase
      sf = ((i / 64) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      drv($urandom_range(0, 2) != 0, mode != 0, DST_W'($urandom), l, sf);
    end
    idle(12, 1'b1);

    chk("seq_wrapped", 32'(saw_wrap), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
